cond_status_unit: RTL and testbench

- Holds the architectural NZCV status register and evaluates ARM condition codes against it.
- Serves LANES condition queries per cycle, with a registered result and stall/flush control.
- Supports masked (partial) flag writes with optional same-cycle forwarding.
- Provides a DEPTH-entry shadow stack for saving and restoring flags around exceptions.
- Sits between the EX-stage flag producer and the issue/commit predicate logic.

---
 rtl/cond_status_unit.sv | 142 ++++++++++++++
 tb/tb_cond_status_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_status_unit.sv
// NZCV status register with masked writes, a LIFO shadow stack for exception
// save/restore, and LANES registered ARM condition-code evaluators.

module cond_lane #(
  parameter int NV_NEVER = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  input  logic       vld,
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass,
  output logic       pass_valid
);
  logic n, z, c, v, eval;

  assign {n, z, c, v} = flags;

  always_comb begin
    eval = 1'b0;
    case (cond)
      4'h0: eval = z;
      4'h1: eval = !z;
      4'h2: eval = c;
      4'h3: eval = !c;
      4'h4: eval = n;
      4'h5: eval = !n;
      4'h6: eval = v;
      4'h7: eval = !v;
      4'h8: eval = c & !z;
      4'h9: eval = !c | z;
      4'hA: eval = (n == v);
      4'hB: eval = (n != v);
      4'hC: eval = !z & (n == v);
      4'hD: eval = z | (n != v);
      4'hE: eval = 1'b1;
      default: eval = (NV_NEVER == 0);
    endcase
  end

  // flush beats stall; both leave the flag path untouched
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pass       <= 1'b0;
      pass_valid <= 1'b0;
    end else if (!stall) begin
      pass       <= eval & vld;
      pass_valid <= vld;
    end
  end
endmodule

module cond_status_unit #(
  parameter int LANES    = 2,
  parameter int DEPTH    = 4,
  parameter int FWD_EN   = 1,
  parameter int NV_NEVER = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flag_we,
  input  logic [3:0]                   flag_in,
  input  logic [3:0]                   flag_mask,
  input  logic                         save_req,
  input  logic                         restore_req,
  input  logic [4*LANES-1:0]           cond_in,
  input  logic [LANES-1:0]             cond_valid,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         err_clr,
  output logic [LANES-1:0]             cond_pass,
  output logic [LANES-1:0]             pass_valid,
  output logic [3:0]                   nzcv_out,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         ovf_err,
  output logic                         unf_err
);
  localparam int DW = $clog2(DEPTH+1);

  logic [3:0]            nzcv, masked, eff, top;
  logic [DEPTH-1:0][3:0] stk;
  logic                  empty, full, pop_ok, swap, push, ovf_ev, unf_ev;
  logic [DW-1:0]         top_idx, wr_idx;

  assign masked  = (nzcv & ~flag_mask) | (flag_in & flag_mask);
  assign empty   = (depth == '0);
  assign full    = (depth == DW'(DEPTH));
  assign top_idx = depth - 1'b1;
  assign pop_ok  = restore_req && !empty;
  assign swap    = save_req && pop_ok;
  // save+restore on an empty stack degrades to a plain push
  assign push    = save_req && !pop_ok && !full;
  assign ovf_ev  = save_req && !pop_ok && full;
  assign unf_ev  = restore_req && empty;
  assign wr_idx  = swap ? top_idx : depth;
  assign eff     = ((FWD_EN != 0) && flag_we && !pop_ok) ? masked : nzcv;

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (DW'(i) == top_idx) top = stk[i];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if ((push || swap) && DW'(i) == wr_idx) stk[i] <= nzcv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv    <= '0;
      depth   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (pop_ok)       nzcv <= top;
      else if (flag_we) nzcv <= masked;
      if (push)                     depth <= depth + 1'b1;
      else if (pop_ok && !save_req) depth <= depth - 1'b1;
      ovf_err <= (ovf_err && !err_clr) || ovf_ev;
      unf_err <= (unf_err && !err_clr) || unf_ev;
    end
  end

  assign nzcv_out = nzcv;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    cond_lane #(.NV_NEVER(NV_NEVER)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .vld        (cond_valid[l]),
      .cond       (cond_in[4*l +: 4]),
      .flags      (eff),
      .pass       (cond_pass[l]),
      .pass_valid (pass_valid[l])
    );
  end
endmodule

// File: tb/tb_cond_status_unit.sv
// Directed plus random checks of cond_status_unit against a queue-based model;
// a second instance with NV_NEVER=1 shares all inputs.

module tb_cond_status_unit;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst, flag_we, save_req, restore_req, stall, flush, err_clr;
  logic [3:0] flag_in, flag_mask;
  logic [4*LANES-1:0] cond_in;
  logic [LANES-1:0] cond_valid;
  logic [LANES-1:0] cp0, pv0, cp1, pv1;
  logic [3:0] nz0, nz1;
  logic [DW-1:0] dp0, dp1;
  logic ovf0, unf0, ovf1, unf1;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_nz;
  logic [3:0] q[$];
  bit m_ovf, m_unf;
  logic [LANES-1:0] m_cp0, m_cp1, m_pv;

  always #5 clk = ~clk;

  cond_status_unit #(.LANES(LANES), .DEPTH(DEPTH), .FWD_EN(1), .NV_NEVER(0)) u_dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in), .flag_mask(flag_mask),
    .save_req(save_req), .restore_req(restore_req), .cond_in(cond_in), .cond_valid(cond_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr), .cond_pass(cp0), .pass_valid(pv0),
    .nzcv_out(nz0), .depth(dp0), .ovf_err(ovf0), .unf_err(unf0));

  cond_status_unit #(.LANES(LANES), .DEPTH(DEPTH), .FWD_EN(1), .NV_NEVER(1)) u_dut_nv (
    .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in), .flag_mask(flag_mask),
    .save_req(save_req), .restore_req(restore_req), .cond_in(cond_in), .cond_valid(cond_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr), .cond_pass(cp1), .pass_valid(pv1),
    .nzcv_out(nz1), .depth(dp1), .ovf_err(ovf1), .unf_err(unf1));

  // ARM-style: odd codes invert the even code's base test; 4'hF is special
  function automatic bit ev(logic [3:0] c, logic [3:0] f, bit nv);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    bit b;
    if (c == 4'hF) return !nv;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; flag_we = 0; flag_in = 0; flag_mask = 0; save_req = 0; restore_req = 0;
    cond_in = 0; cond_valid = 0; stall = 0; flush = 0; err_clr = 0;
  endtask

  task automatic tick();
    int sz = q.size();
    bit pop_ok = restore_req && sz > 0;
    bit ovf_ev = 0, unf_ev = 0;
    logic [3:0] masked = (m_nz & ~flag_mask) | (flag_in & flag_mask);
    logic [3:0] eff = (flag_we && !pop_ok) ? masked : m_nz;
    logic [3:0] t;
    if (rst) begin
      m_nz = 0; q.delete(); m_ovf = 0; m_unf = 0; m_cp0 = 0; m_cp1 = 0; m_pv = 0;
    end else begin
      if (flush) begin
        m_pv = 0; m_cp0 = 0; m_cp1 = 0;
      end else if (!stall) begin
        m_pv = cond_valid;
        for (int l = 0; l < LANES; l++) begin
          m_cp0[l] = cond_valid[l] && ev(cond_in[4*l +: 4], eff, 0);
          m_cp1[l] = cond_valid[l] && ev(cond_in[4*l +: 4], eff, 1);
        end
      end
      if (pop_ok && save_req) begin
        t = q.pop_back(); q.push_back(m_nz); m_nz = t;
      end else if (pop_ok) begin
        m_nz = q.pop_back();
      end else begin
        if (restore_req) unf_ev = 1;
        if (save_req) begin
          if (sz == DEPTH) ovf_ev = 1;
          else q.push_back(m_nz);
        end
        if (flag_we) m_nz = masked;
      end
      m_ovf = (m_ovf && !err_clr) || ovf_ev;
      m_unf = (m_unf && !err_clr) || unf_ev;
    end
    @(posedge clk);
    #1;
    chk("cond_pass",    8'(cp0), 8'(m_cp0));
    chk("pass_valid",   8'(pv0), 8'(m_pv));
    chk("nv_cond_pass", 8'(cp1), 8'(m_cp1));
    chk("nv_pass_valid", 8'(pv1), 8'(m_pv));
    chk("nzcv_out",     8'(nz0), 8'(m_nz));
    chk("depth",        8'(dp0), 8'(q.size()));
    chk("ovf_err",      8'(ovf0), 8'(m_ovf));
    chk("unf_err",      8'(unf0), 8'(m_unf));
    chk("nv_state",     {nz1, 1'b0, dp1}, {m_nz, 1'b0, 3'(q.size())});
  endtask

  initial begin
    m_nz = 0; m_ovf = 0; m_unf = 0; m_cp0 = 0; m_cp1 = 0; m_pv = 0;
    idle(); rst = 1; tick(); tick();

    // forwarded write seen by EQ/NE in the same cycle
    idle(); flag_we = 1; flag_in = 4'b0100; flag_mask = 4'hF;
    cond_in = {4'h1, 4'h0}; cond_valid = 2'b11; tick();
    chk("t1_pass", 8'(cp0), 8'h01);
    chk("t1_nzcv", 8'(nz0), 8'h04);

    // partial mask, then GT/LE and HI/LS
    idle(); flag_we = 1; flag_in = 4'b1001; flag_mask = 4'hF; tick();
    idle(); flag_we = 1; flag_in = 4'b0110; flag_mask = 4'b0110; tick();
    chk("t2_nzcv", 8'(nz0), 8'h0F);
    idle(); cond_in = {4'hD, 4'hC}; cond_valid = 2'b11; tick();
    chk("t2_gt_le", 8'(cp0), 8'h02);
    idle(); cond_in = {4'h9, 4'h8}; cond_valid = 2'b11; tick();
    chk("t2_hi_ls", 8'(cp0), 8'h02);

    // fill, overflow, drain, underflow
    idle(); rst = 1; tick();
    idle(); flag_we = 1; flag_in = 4'h1; flag_mask = 4'hF; tick();
    for (int v = 2; v <= 4; v++) begin
      idle(); save_req = 1; flag_we = 1; flag_in = 4'(v); flag_mask = 4'hF; tick();
    end
    idle(); save_req = 1; tick();
    idle(); save_req = 1; tick();
    chk("t3_depth_full", 8'(dp0), 8'h04);
    chk("t3_ovf", 8'(ovf0), 8'h01);
    for (int k = 4; k >= 1; k--) begin
      idle(); restore_req = 1; tick();
      chk("t3_pop", 8'(nz0), 8'(k));
    end
    idle(); restore_req = 1; tick();
    chk("t3_unf", 8'(unf0), 8'h01);
    chk("t3_nz_hold", 8'(nz0), 8'h01);

    // swap with a dropped flag write
    idle(); rst = 1; tick();
    idle(); flag_we = 1; flag_in = 4'hA; flag_mask = 4'hF; tick();
    idle(); save_req = 1; flag_we = 1; flag_in = 4'h3; flag_mask = 4'hF; tick();
    idle(); save_req = 1; restore_req = 1; flag_we = 1; flag_in = 4'hF; flag_mask = 4'hF; tick();
    chk("t4_swap_nz", 8'(nz0), 8'h0A);
    chk("t4_swap_depth", 8'(dp0), 8'h01);
    idle(); restore_req = 1; tick();
    chk("t4_old_top", 8'(nz0), 8'h03);

    // stall hold, then flush over stall
    idle(); cond_in = {4'hE, 4'hE}; cond_valid = 2'b11; tick();
    for (int k = 0; k < 3; k++) begin
      idle(); stall = 1; cond_in = {4'h2, 4'h0}; cond_valid = 2'b01; tick();
      chk("t5_stall_hold", {pv0, cp0}, 8'h0F);
    end
    idle(); stall = 1; flush = 1; cond_valid = 2'b11; tick();
    chk("t5_flush", 8'(pv0), 8'h00);

    // cond 4'hF on both variants, then reset mid-stack
    idle(); cond_in = {4'hF, 4'hF}; cond_valid = 2'b11; tick();
    chk("t6_nv0", 8'(cp0), 8'h03);
    chk("t6_nv1", 8'(cp1), 8'h00);
    idle(); save_req = 1; tick(); tick();
    idle(); rst = 1; cond_valid = 2'b11; cond_in = {4'hE, 4'hE}; tick();
    chk("t6_rst", {pv0, cp0, nz0, 1'b0, dp0}, 16'h0);

    for (int it = 0; it < 400; it++) begin
      idle();
      rst         = ($urandom_range(63) == 0);
      flag_we     = $urandom_range(1);
      flag_in     = 4'($urandom);
      flag_mask   = 4'($urandom);
      save_req    = ($urandom_range(3) == 0);
      restore_req = ($urandom_range(3) == 0);
      cond_in     = 8'($urandom);
      cond_valid  = 2'($urandom);
      stall       = ($urandom_range(5) == 0);
      flush       = ($urandom_range(7) == 0);
      err_clr     = ($urandom_range(7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
